aes_host_bridge: RTL and testbench

- Parametrised, strobed host-to-AES bridge: the successor to the fixed 16-in/8-out AES pin wrapper.
- It accepts key, block, config and start commands over a narrow IN_W-bit write bus and drives the AES core control and data ports directly.
- It captures each core result and returns it over an OUT_W-bit read bus.
- Compared with the earlier wrapper it adds explicit wr_en/rd_en strobes, per-target word pointers, command guarding and a sticky error/overrun status; the AES core remains a separate instance.

---
 rtl/aes_host_bridge.sv | 249 ++++++++++++++++++++++++
 tb/tb_aes_host_bridge.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_host_bridge.sv
// aes_host_bridge
//   Host-side register bridge in front of an AES core. The host streams key,
//   block and config words over a narrow IN_W-bit write bus, fires init/next
//   commands, and drains the captured 128-bit result over an OUT_W-bit read
//   bus. The AES core itself is a separate instance wired to the core_* ports.
//
// Parameters
//   IN_W   write-bus width (8, 16, 32 or 64)
//   OUT_W  read-bus width  (8, 16, 32 or 64)
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   address         1 CONFIG, 2 KEY, 3 BLOCK, 5 STATUS, 6 START, 7 RESULT
//   wr_en, rd_en    one-beat write / read strobes (both may be active at once)
//   data_in         write data
//   data_out        registered read data, holds between reads
//   core_encdec     1 = encrypt, 0 = decrypt
//   core_keylen     1 = 256-bit key, 0 = 128-bit key
//   core_init       one-cycle key-expansion pulse
//   core_next       one-cycle block-start pulse
//   core_key        key, word 0 in the MSBs; low half zero for 128-bit keys
//   core_block      block, word 0 in the MSBs
//   core_ready      core idle
//   core_result     core output block
//   core_valid      core result valid (level; rising edge captures)
module aes_host_bridge #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       address,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [IN_W-1:0]  data_in,
    output logic [OUT_W-1:0] data_out,
    output logic             core_encdec,
    output logic             core_keylen,
    output logic             core_init,
    output logic             core_next,
    output logic [255:0]     core_key,
    output logic [127:0]     core_block,
    input  logic             core_ready,
    input  logic [127:0]     core_result,
    input  logic             core_valid
);

    localparam int KEY_MAX   = 256 / IN_W;
    localparam int BLK_WORDS = 128 / IN_W;
    localparam int RES_WORDS = 128 / OUT_W;
    localparam int KPW       = $clog2(KEY_MAX);
    localparam int BPW       = $clog2(BLK_WORDS);
    localparam int RPW       = $clog2(RES_WORDS);

    localparam logic [KPW-1:0] KEY_TOP      = KPW'(KEY_MAX - 1);
    localparam logic [KPW-1:0] KEY_LAST_128 = KPW'(KEY_MAX / 2 - 1);
    localparam logic [BPW-1:0] BLK_TOP      = BPW'(BLK_WORDS - 1);
    localparam logic [RPW-1:0] RES_TOP      = RPW'(RES_WORDS - 1);

    // Command accepted on edge N, pulse visible after edge N+1.
    localparam int PULSE_STAGES = 2;

    localparam logic [3:0] ADDR_CONFIG = 4'd1;
    localparam logic [3:0] ADDR_KEY    = 4'd2;
    localparam logic [3:0] ADDR_BLOCK  = 4'd3;
    localparam logic [3:0] ADDR_STATUS = 4'd5;
    localparam logic [3:0] ADDR_START  = 4'd6;
    localparam logic [3:0] ADDR_RESULT = 4'd7;

    typedef struct packed {
        logic ovr;
        logic err;
        logic res_avail;
        logic block_full;
        logic key_inited;
        logic key_full;
        logic core_valid;
        logic core_ready;
    } status_t;

    // Word 0 sits at the highest packed index so it lands in the MSBs.
    logic [KEY_MAX-1:0][IN_W-1:0]    key_words;
    logic [BLK_WORDS-1:0][IN_W-1:0]  blk_words;
    logic [RES_WORDS-1:0][OUT_W-1:0] result_buf;
    logic [255:0]                    key_flat;

    logic [KPW-1:0] key_ptr;
    logic [BPW-1:0] blk_ptr;
    logic [RPW-1:0] res_ptr;

    logic key_full, key_inited, block_full, res_avail, err, ovr, valid_d;
    logic [PULSE_STAGES-1:0] init_pipe, next_pipe;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic addr_valid;
    logic wr_cfg, wr_key, wr_blk, wr_start, wr_data, busy_wr;
    logic start_init, start_next, init_ok, next_ok, start_err;
    logic rd_status, rd_result, res_read_ok, res_read_err, res_last;
    logic capture, err_set, ovr_set, key_last;
    status_t status;
    logic [OUT_W-1:0] rd_data;

    assign addr_valid = address inside {ADDR_CONFIG, ADDR_KEY, ADDR_BLOCK,
                                        ADDR_STATUS, ADDR_START, ADDR_RESULT};

    assign wr_cfg   = wr_en && (address == ADDR_CONFIG);
    assign wr_key   = wr_en && (address == ADDR_KEY);
    assign wr_blk   = wr_en && (address == ADDR_BLOCK);
    assign wr_start = wr_en && (address == ADDR_START);

    // Loading operands while the core is working would corrupt its inputs.
    assign wr_data = (wr_cfg || wr_key || wr_blk) && core_ready;
    assign busy_wr = (wr_cfg || wr_key || wr_blk) && !core_ready;

    assign start_init = wr_start && data_in[0];
    assign start_next = wr_start && data_in[1];
    assign init_ok    = start_init && core_ready && key_full;
    // init has priority: with both bits set next is never accepted.
    assign next_ok    = start_next && !start_init && core_ready && key_inited && block_full;
    assign start_err  = (start_init && !init_ok) || (start_next && !next_ok);

    assign rd_status    = rd_en && (address == ADDR_STATUS);
    assign rd_result    = rd_en && (address == ADDR_RESULT);
    assign res_read_ok  = rd_result && res_avail;
    assign res_read_err = rd_result && !res_avail;
    assign res_last     = (res_ptr == RES_TOP);

    assign capture = core_valid && !valid_d;
    // A capture landing on the final chunk read is a clean hand-over.
    assign ovr_set = capture && res_avail && !(res_read_ok && res_last);
    assign err_set = busy_wr || start_err || res_read_err ||
                     ((wr_en || rd_en) && !addr_valid);

    assign key_last = (key_ptr == (core_keylen ? KEY_TOP : KEY_LAST_128));

    always_comb begin
        status            = '0;
        status.ovr        = ovr;
        status.err        = err;
        status.res_avail  = res_avail;
        status.block_full = block_full;
        status.key_inited = key_inited;
        status.key_full   = key_full;
        status.core_valid = core_valid;
        status.core_ready = core_ready;
    end

    // Reads see pre-write register state; writes in the same cycle land later.
    always_comb begin
        rd_data = '0;
        case (address)
            ADDR_STATUS: rd_data = OUT_W'(status);
            ADDR_START:  rd_data = OUT_W'({core_keylen, core_encdec, key_inited, block_full});
            ADDR_RESULT: if (res_avail) rd_data = result_buf[RES_TOP - res_ptr];
            default:     rd_data = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out    <= '0;
            core_encdec <= 1'b0;
            core_keylen <= 1'b0;
            key_words   <= '0;
            blk_words   <= '0;
            result_buf  <= '0;
            key_ptr     <= '0;
            blk_ptr     <= '0;
            res_ptr     <= '0;
            key_full    <= 1'b0;
            key_inited  <= 1'b0;
            block_full  <= 1'b0;
            res_avail   <= 1'b0;
            err         <= 1'b0;
            ovr         <= 1'b0;
            valid_d     <= 1'b0;
            init_pipe   <= '0;
            next_pipe   <= '0;
        end else begin
            valid_d   <= core_valid;
            init_pipe <= {init_pipe[PULSE_STAGES-2:0], init_ok};
            next_pipe <= {next_pipe[PULSE_STAGES-2:0], next_ok};

            if (rd_en) data_out <= rd_data;

            // Configuration restarts the key load from word 0.
            if (wr_data && wr_cfg) begin
                core_encdec <= data_in[0];
                core_keylen <= data_in[1];
                key_ptr     <= '0;
                key_full    <= 1'b0;
                key_inited  <= 1'b0;
            end

            if (wr_data && wr_key) begin
                key_words[KEY_TOP - key_ptr] <= data_in;
                if (key_last) begin
                    key_ptr    <= '0;
                    key_full   <= 1'b1;
                    key_inited <= 1'b0;
                end else begin
                    key_ptr <= key_ptr + 1'b1;
                end
            end

            if (wr_data && wr_blk) begin
                blk_words[BLK_TOP - blk_ptr] <= data_in;
                if (blk_ptr == BLK_TOP) begin
                    blk_ptr    <= '0;
                    block_full <= 1'b1;
                end else begin
                    blk_ptr <= blk_ptr + 1'b1;
                end
            end

            if (init_ok) key_inited <= 1'b1;
            if (next_ok) block_full <= 1'b0;

            if (capture) begin
                result_buf <= core_result;
                res_avail  <= 1'b1;
                res_ptr    <= '0;
            end else if (res_read_ok) begin
                if (res_last) begin
                    res_avail <= 1'b0;
                    res_ptr   <= '0;
                end else begin
                    res_ptr <= res_ptr + 1'b1;
                end
            end

            // STATUS read clears the sticky bits; fresh sets win.
            err <= (err && !rd_status) || err_set;
            ovr <= (ovr && !rd_status) || ovr_set;
        end
    end

    assign core_init  = init_pipe[PULSE_STAGES-1];
    assign core_next  = next_pipe[PULSE_STAGES-1];
    assign key_flat   = key_words;
    assign core_key   = core_keylen ? key_flat : {key_flat[255:128], 128'd0};
    assign core_block = blk_words;

endmodule

// File: tb/tb_aes_host_bridge.sv
module tb_aes_host_bridge;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    always #5 clk = ~clk;

    // 16-in / 8-out instance
    logic [3:0]   address = '0;
    logic         wr_en = 1'b0, rd_en = 1'b0;
    logic [15:0]  data_in = '0;
    logic [7:0]   data_out;
    logic         core_encdec, core_keylen, core_init, core_next;
    logic [255:0] core_key;
    logic [127:0] core_block;
    logic         core_ready = 1'b1;
    logic [127:0] core_result = '0;
    logic         core_valid = 1'b0;

    // 32-in / 32-out instance
    logic [3:0]   a32 = '0;
    logic         wr32 = 1'b0, rd32 = 1'b0;
    logic [31:0]  din32 = '0;
    logic [31:0]  dout32;
    logic         encdec32, keylen32, init32, next32;
    logic [255:0] key32;
    logic [127:0] block32;
    logic         ready32 = 1'b1;
    logic [127:0] res32 = '0;
    logic         valid32 = 1'b0;

    aes_host_bridge #(.IN_W(16), .OUT_W(8)) dut (
        .clk(clk), .rst(rst), .address(address), .wr_en(wr_en), .rd_en(rd_en),
        .data_in(data_in), .data_out(data_out), .core_encdec(core_encdec),
        .core_keylen(core_keylen), .core_init(core_init), .core_next(core_next),
        .core_key(core_key), .core_block(core_block), .core_ready(core_ready),
        .core_result(core_result), .core_valid(core_valid)
    );

    aes_host_bridge #(.IN_W(32), .OUT_W(32)) dut32 (
        .clk(clk), .rst(rst), .address(a32), .wr_en(wr32), .rd_en(rd32),
        .data_in(din32), .data_out(dout32), .core_encdec(encdec32),
        .core_keylen(keylen32), .core_init(init32), .core_next(next32),
        .core_key(key32), .core_block(block32), .core_ready(ready32),
        .core_result(res32), .core_valid(valid32)
    );

    localparam logic [127:0] RES_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] RES_B = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] RES_C = 128'hdeadbeef00000000cafef00d11111111;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] din;
        logic [7:0]  exp;
    } vec_t;
    vec_t tbl[14];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        address = a; data_in = d; wr_en = 1'b1;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        address = a; rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        d = data_out;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
        logic [7:0] d;
        rd(a, d);
        check(name, d, exp);
    endtask

    // Called right after a START write returns; a pulse is expected only
    // in the middle of the three sampled cycles.
    task automatic check_pulse(input string name, input bit is_init, input bit want);
        for (int k = 0; k < 3; k++) begin
            check(name, is_init ? core_init : core_next, (want && k == 1) ? 1'b1 : 1'b0);
            if (k < 2) cyc();
        end
    endtask

    task automatic pulse_valid(input logic [127:0] r);
        core_result = r; core_valid = 1'b1;
        cyc(); cyc();
        core_valid = 1'b0;
        cyc();
    endtask

    // Back-to-back RESULT reads, scoreboarded one cycle behind rd_en.
    task automatic read_res8(input int n, input int first, input logic [127:0] r);
        address = 4'd7; rd_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(32'(r[127 - 8*(first + i) -: 8]));
            cyc();
            check("result8", 32'(data_out), exp_q.pop_front());
        end
        rd_en = 1'b0;
    endtask

    task automatic wr32_t(input logic [3:0] a, input logic [31:0] d);
        a32 = a; din32 = d; wr32 = 1'b1;
        cyc();
        wr32 = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] exp_key;
        logic [7:0]   d;

        // ---------------- table: config, 128-bit key load, reads ----------
        tbl[0] = '{1'b1, 4'd1, 16'h0001, 8'h00};
        for (int k = 0; k < 8; k++)
            tbl[1 + k] = '{1'b1, 4'd2, 16'(k * 16'h0202 + 16'h0001), 8'h00};
        tbl[9]  = '{1'b0, 4'd6, 16'h0, 8'h04};  // encdec=1
        tbl[10] = '{1'b0, 4'd5, 16'h0, 8'h05};  // key_full, ready
        tbl[11] = '{1'b0, 4'd4, 16'h0, 8'h00};  // invalid address
        tbl[12] = '{1'b0, 4'd5, 16'h0, 8'h45};  // err seen
        tbl[13] = '{1'b0, 4'd5, 16'h0, 8'h05};  // err cleared by previous read

        // ---------------- reset ----------------
        cyc(); cyc();
        check("rst_data_out", data_out, 8'h00);
        check("rst_pulses", {core_init, core_next, core_encdec, core_keylen}, 4'h0);
        check("rst_key", core_key, 256'h0);
        check("rst_block", core_block, 128'h0);
        rst = 1'b0;
        cyc();

        // ---------------- test 1 ----------------
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].wr) wr(tbl[i].addr, tbl[i].din);
            else begin
                rd(tbl[i].addr, d);
                check($sformatf("tbl%0d", i), d, tbl[i].exp);
            end
        end
        check("key128", core_key, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        check("cfg_out", {core_encdec, core_keylen}, 2'b10);
        wr(4'd6, 16'h0001);
        check_pulse("init_pulse", 1'b1, 1'b1);
        rd_chk("status_inited", 4'd5, 8'h0d);

        // ---------------- test 2 ----------------
        for (int k = 0; k < 8; k++) wr(4'd3, 16'(k * 16'h2222 + 16'h0011));
        check("block", core_block, 128'h00112233445566778899aabbccddeeff);
        rd_chk("status_blk", 4'd5, 8'h1d);
        wr(4'd6, 16'h0002);
        check_pulse("next_pulse", 1'b0, 1'b1);
        core_ready = 1'b0;
        repeat (3) cyc();
        core_ready = 1'b1;
        pulse_valid(RES_A);
        read_res8(16, 0, RES_A);
        rd_chk("status_drained", 4'd5, 8'h0d);

        // ---------------- test 3 ----------------
        wr(4'd6, 16'h0002);
        check_pulse("next_rejected", 1'b0, 1'b0);
        rd_chk("status_err", 4'd5, 8'h4d);
        rd_chk("status_err_clr", 4'd5, 8'h0d);
        wr(4'd6, 16'h0003);  // both bits: init wins, err set
        check_pulse("both_init", 1'b1, 1'b1);
        rd_chk("status_both", 4'd5, 8'h4d);

        // ---------------- test 4 ----------------
        core_ready = 1'b0;
        wr(4'd2, 16'hffff);
        check("busy_key", core_key, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        rd_chk("status_busy", 4'd5, 8'h4c);
        core_ready = 1'b1;
        wr(4'd1, 16'h0003);
        exp_key = '0;
        for (int k = 0; k < 16; k++) begin
            wr(4'd2, 16'h1000 + 16'(k));
            exp_key[255 - 16*k -: 16] = 16'h1000 + 16'(k);
            if (k == 14) rd_chk("key256_15", 4'd5, 8'h01);
        end
        rd_chk("key256_16", 4'd5, 8'h05);
        check("key256", core_key, exp_key);
        check("keylen_out", core_keylen, 1'b1);

        // ---------------- test 5 ----------------
        pulse_valid(RES_C);
        pulse_valid(RES_B);
        rd_chk("status_ovr", 4'd5, 8'ha5);
        read_res8(4, 0, RES_B);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst_mid_dout", data_out, 8'h00);
        check("rst_mid_key", {core_key, core_keylen, core_encdec}, 258'h0);
        rd_chk("status_after_rst", 4'd5, 8'h01);
        rd_chk("res_empty", 4'd7, 8'h00);
        rd_chk("status_empty_err", 4'd5, 8'h41);

        // capture coinciding with the final chunk read
        pulse_valid(RES_A);
        read_res8(15, 0, RES_A);
        address = 4'd7; rd_en = 1'b1;
        core_result = RES_B; core_valid = 1'b1;
        cyc();
        rd_en = 1'b0;
        check("coincide_last", data_out, RES_A[7:0]);
        cyc();
        core_valid = 1'b0;
        cyc();
        rd_chk("coincide_status", 4'd5, 8'h21);
        rd_chk("coincide_first", 4'd7, RES_B[127:120]);

        // ---------------- test 6: 32/32 instance ----------------
        wr32_t(4'd3, 32'h00112233);
        wr32_t(4'd3, 32'h44556677);
        wr32_t(4'd3, 32'h8899aabb);
        wr32_t(4'd3, 32'hccddeeff);
        check("block32", block32, 128'h00112233445566778899aabbccddeeff);
        res32 = RES_A; valid32 = 1'b1;
        cyc(); cyc();
        valid32 = 1'b0;
        cyc();
        a32 = 4'd7; rd32 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(RES_A[127 - 32*i -: 32]);
            cyc();
            check("result32", dout32, exp_q.pop_front());
        end
        a32 = 4'd5;
        cyc();
        rd32 = 1'b0;
        check("status32", dout32, 32'h11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
